ncl_mr_tx: RTL and testbench
============================

# ncl_mr_tx

Synchronous-to-NCL transmitter for 1-of-N multi-rail rings and pipelines. It accepts binary symbols on a valid/ready port and buffers them in a DEPTH-entry FIFO. Each symbol is emitted as a one-hot DATA wavefront, followed by an all-zero NULL wavefront, paced by the downstream completion signal. It sits at the boundary between the clocked test/control logic and a clockless multi-rail pipeline ring, and replaces hand-initialised ring seeding with a parametrised, flow-controlled source.

## Interface
Parameters:
- RAILS, 4, rails per channel (1-of-RAILS code); power of two, 2..16
- DEPTH, 4, FIFO entries; power of two, >=2
- SYNC_STAGES, 2, flops in the mr_ack synchroniser; >=2
- TIMEOUT, 256, watchdog limit in cycles (used only with NCL_MR_TX_WDOG_EN)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - init_n  in  1  asynchronous active-low reset
- Input port:
  - in_valid  in  1  symbol offered
  - in_ready  out  1  FIFO can accept
  - in_data  in  log2(RAILS)  binary symbol
- Multi-rail side:
  - mr_out  out  RAILS  multi-rail wavefront to first NCL stage; registered
  - mr_ack  in  1  asynchronous completion from downstream stage; high = DATA held, low = NULL held
- Status:
  - count  out  log2(DEPTH)+1  FIFO occupancy
  - busy  out  1  FSM not in NULL state or FIFO non-empty
  - err  out  1  sticky watchdog flag

## Operation
- Reset (init_n low, effective immediately, no clock needed):
  - mr_out=0, count=0, in_ready=0, busy=0, err=0.
  - FIFO pointers are cleared and synchroniser flops are cleared.
  - FSM goes to NULL.
  - in_ready rises at the first clk edge after init_n deasserts.
- FIFO:
  - A push occurs when in_valid && in_ready at a rising edge. in_ready = !full.
  - A pop occurs only on the NULL->DATA transition.
  - Push and pop in the same cycle leave count unchanged.
  - A push while full is impossible because in_ready is low.
  - Pointers wrap modulo DEPTH.
- ack_s is mr_ack after SYNC_STAGES flops.
- FSM:
  - NULL: mr_out=0. If ack_s==0 and count>0, pop the head, register mr_out = 1<<head and go to DATA. Otherwise stay.
  - DATA: hold mr_out. When ack_s==1, register mr_out=0 and go to NULL.
- Completion discipline:
  - DATA is never launched while ack_s==1. This covers a downstream stage holding stale DATA out of reset.
  - Each DATA wavefront is separated by a NULL wavefront that the downstream stage has acknowledged.
- mr_out is always either all-zero or exactly one-hot. No other pattern ever appears, including across reset.
- Reset mid-wavefront: mr_out drops to 0 and FIFO contents are lost. After release, the first DATA waits for ack_s==0.

## Timing
- Symbol accepted at edge k into an empty FIFO, with FSM in NULL and ack_s==0: one-hot appears on mr_out after edge k+1.
- mr_ack rise -> mr_out NULL after SYNC_STAGES+1 edges.
- mr_ack fall -> next DATA after SYNC_STAGES+1 edges, if the FIFO is non-empty.
- Steady-state throughput is one symbol per 2*(SYNC_STAGES+1) cycles plus the downstream ring delay.
- count updates at the edge of each push/pop. in_ready is combinational from count.

## Configuration
- NCL_MR_TX_WDOG_EN defined:
  - A 16-bit wait counter clears on every FSM transition and increments each cycle spent in DATA, or in NULL with ack_s==1.
  - When the counter reaches TIMEOUT, err is set. It stays set until init_n is asserted.
  - The counter saturates.
  - The FSM keeps waiting; there is no forced recovery.
- Not defined: the counter is absent and err is tied to 0.

## Test plan
- Reset then single push: in_data=2 with RAILS=4 and mr_ack looped through a 3-cycle model of a downstream stage. Required: mr_out 0000 -> 0100 -> 0000; count 1 -> 0; in_ready stays high.
- Fill: push 5 symbols with mr_ack held low. Required: 1st symbol launches; 4 fill the FIFO; in_ready=0 at count=4; the 5th is held off until a pop.
- Simultaneous push/pop at count=4: release mr_ack through a full cycle. Required: count stays 4 across the pop edge if in_valid is high; order is preserved (send 0,1,2,3 -> observe 0001, 0010, 0100, 1000).
- Stale ack: mr_ack=1 through reset release with FIFO loaded. Required: mr_out stays 0 until SYNC_STAGES+1 edges after mr_ack falls, then one-hot.
- Reset mid-DATA: assert init_n low while mr_out=1000. Required: mr_out=0000 and count=0 asynchronously, before the next clk edge.
- With NCL_MR_TX_WDOG_EN and TIMEOUT=16: launch DATA and never raise mr_ack. Required: err rises at cycle 16 after launch and stays high until reset; without the macro, err stays 0.

Source files
------------

// File: rtl/ncl_mr_tx.sv
// ----------------------------------------------------------------------------
// ncl_mr_tx : synchronous-to-NCL 1-of-RAILS multi-rail transmitter.
//
// Binary symbols enter through a valid/ready port into a DEPTH-entry FIFO.
// Each symbol leaves as a one-hot DATA wavefront on mr_out. An all-zero NULL
// wavefront follows it. Both are paced by the synchronised downstream
// completion signal mr_ack.
//
// Ports:
//   clk       in   clock
//   init_n    in   asynchronous active-low reset
//   in_valid  in   symbol offered
//   in_ready  out  FIFO can accept (combinational from occupancy)
//   in_data   in   binary symbol, $clog2(RAILS) bits
//   mr_out    out  registered multi-rail wavefront, RAILS bits
//   mr_ack    in   asynchronous completion (1 = DATA held, 0 = NULL held)
//   count     out  FIFO occupancy, $clog2(DEPTH)+1 bits
//   busy      out  wavefront in flight or FIFO non-empty
//   err       out  sticky watchdog flag
//
// Optional feature macro: NCL_MR_TX_WDOG_EN enables the wait watchdog that
// drives err. Without it, err is tied low.
// ----------------------------------------------------------------------------
module ncl_mr_tx #(
    parameter int RAILS       = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 256
) (
    input  logic                       clk,
    input  logic                       init_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(RAILS)-1:0]   in_data,
    output logic [RAILS-1:0]           mr_out,
    input  logic                       mr_ack,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       err
);

    localparam int DW = $clog2(RAILS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        ST_NULL = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_mem [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_rdy_en;
    state_t                 r_state;
    logic [RAILS-1:0]       r_mr_out;

    logic                   w_ack_s;
    logic                   w_push;
    logic                   w_pop;
    logic [RAILS-1:0]       w_onehot;

    assign w_ack_s  = r_sync[SYNC_STAGES-1];
    // in_ready stays low until the first edge after reset release.
    assign in_ready = r_rdy_en && (r_count != FULL_CNT);
    assign w_push   = in_valid && in_ready;
    // A symbol is launched only from NULL, and only after downstream has
    // acknowledged NULL. A stale DATA held downstream therefore blocks launch.
    assign w_pop    = (r_state == ST_NULL) && !w_ack_s && (r_count != '0);
    assign w_onehot = {{(RAILS-1){1'b0}}, 1'b1} << r_mem[r_rd_ptr];

    assign mr_out = r_mr_out;
    assign count  = r_count;
    assign busy   = (r_state != ST_NULL) || (r_count != '0);

    // Synchroniser for the asynchronous completion input.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], mr_ack};
        end
    end

    // FIFO storage. Its contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the post-reset ready enable.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // DATA/NULL handshake FSM with registered wavefront output.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_state  <= ST_NULL;
            r_mr_out <= '0;
        end else begin
            case (r_state)
                ST_NULL: begin
                    if (w_pop) begin
                        r_mr_out <= w_onehot;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_ack_s) begin
                        r_mr_out <= '0;
                        r_state  <= ST_NULL;
                    end
                end
                default: begin
                    r_mr_out <= '0;
                    r_state  <= ST_NULL;
                end
            endcase
        end
    end

`ifdef NCL_MR_TX_WDOG_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [15:0] r_wait;
    logic [15:0] w_wait_nxt;
    logic        r_err;
    logic        w_trans;
    logic        w_waiting;

    assign w_trans   = w_pop || ((r_state == ST_DATA) && w_ack_s);
    assign w_waiting = (r_state == ST_DATA) || w_ack_s;

    // Next wait-counter value: cleared on transitions, saturating otherwise.
    always_comb begin
        w_wait_nxt = r_wait;
        if (w_trans) begin
            w_wait_nxt = 16'd0;
        end else if (w_waiting && (r_wait != 16'hFFFF)) begin
            w_wait_nxt = r_wait + 16'd1;
        end else begin
            w_wait_nxt = r_wait;
        end
    end

    // Wait counter and sticky error flag. Only reset clears the flag.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_wait <= 16'd0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= w_wait_nxt;
            if (w_wait_nxt >= TIMEOUT_W) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    // TIMEOUT only configures the watchdog, which is absent in this build.
    logic w_unused_cfg;
    assign w_unused_cfg = ^(32'(TIMEOUT));
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_mr_tx.sv
// ----------------------------------------------------------------------------
// tb_ncl_mr_tx : self-checking bench for ncl_mr_tx (RAILS=4, DEPTH=4,
// SYNC_STAGES=2, TIMEOUT=16). A queue-based model predicts the outputs.
// A 3-cycle downstream stage model (or a manual level) drives mr_ack.
// ----------------------------------------------------------------------------
module tb_ncl_mr_tx;

    localparam int RAILS = 4;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int TO    = 16;

    logic       clk      = 1'b0;
    logic       init_n   = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_data  = 2'd0;
    logic       in_ready;
    logic [3:0] mr_out;
    logic       mr_ack;
    logic [2:0] count;
    logic       busy;
    logic       err;

    logic       ack_auto = 1'b0;
    logic       ack_man  = 1'b0;
    logic [2:0] ds_dly   = 3'd0;

    int chk_cnt = 0;
    int err_cnt = 0;

    ncl_mr_tx #(
        .RAILS(RAILS), .DEPTH(DEPTH), .SYNC_STAGES(SS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .init_n(init_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mr_out(mr_out), .mr_ack(mr_ack), .count(count),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Downstream stage: acknowledges the wavefront it saw three cycles earlier.
    always @(posedge clk) ds_dly <= {ds_dly[1:0], |mr_out};
    assign mr_ack = ack_auto ? ds_dly[2] : ack_man;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: symbol queue, delayed view of mr_ack, one flag that
    // records whether a DATA wavefront is outstanding.
    int         q[$];
    logic       m_data    = 1'b0;
    logic       m_started = 1'b0;
    logic [3:0] m_out     = 4'd0;
    logic       hist[SS];

    initial begin
        for (int i = 0; i < SS; i++) hist[i] = 1'b0;
        forever begin
            @(posedge clk or negedge init_n);
            if (!init_n) begin
                q.delete();
                m_data = 1'b0;
                m_started = 1'b0;
                m_out = 4'd0;
                for (int i = 0; i < SS; i++) hist[i] = 1'b0;
            end else begin
                logic ack_seen;
                logic do_push;
                ack_seen = hist[SS-1];
                do_push  = in_valid && m_started && (q.size() < DEPTH);
                if (!m_data && !ack_seen && q.size() > 0) begin
                    m_out  = 4'b0001 << q.pop_front();
                    m_data = 1'b1;
                end else if (m_data && ack_seen) begin
                    m_out  = 4'd0;
                    m_data = 1'b0;
                end
                if (do_push) q.push_back(int'(in_data));
                for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = mr_ack;
                m_started = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of launched symbols.
    logic [3:0] launches[$];
    logic [3:0] prev_out = 4'd0;
    initial begin
        forever begin
            @(negedge clk);
            chk("mr_out", 32'(mr_out), 32'(m_out));
            chk("count", 32'(count), 32'(q.size()));
            chk("in_ready", 32'(in_ready), 32'(m_started && (q.size() < DEPTH)));
            chk("busy", 32'(busy), 32'(m_data || (q.size() > 0)));
            chk("onehot0", 32'($onehot0(mr_out)), 32'd1);
`ifndef NCL_MR_TX_WDOG_EN
            chk("err_zero", 32'(err), 32'd0);
`endif
            if (mr_out != 4'd0 && prev_out == 4'd0) launches.push_back(mr_out);
            prev_out = mr_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic       acc;
        logic [3:0] exp_l[6];
        exp_l = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_mr_out", 32'(mr_out), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        init_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Single symbol through the looped downstream stage.
        ack_auto = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_null", 32'(mr_out), 32'd0);
        @(negedge clk);
        chk("t1_data", 32'(mr_out), 32'b0100);
        chk("t1_count0", 32'(count), 32'd0);
        for (int i = 0; i < 20 && mr_out != 4'd0; i++) @(negedge clk);
        chk("t1_null_back", 32'(mr_out), 32'd0);
        repeat (10) @(negedge clk);

        // Fill with mr_ack held low.
        ack_auto = 1'b0; ack_man = 1'b0;
        launches.delete();
        in_valid = 1'b1; in_data = 2'd3;
        @(negedge clk); in_data = 2'd0;
        @(negedge clk); in_data = 2'd1;
        @(negedge clk); in_data = 2'd2;
        @(negedge clk); in_data = 2'd3;
        @(negedge clk);
        chk("fill_count4", 32'(count), 32'd4);
        chk("fill_ready0", 32'(in_ready), 32'd0);
        chk("fill_data", 32'(mr_out), 32'b1000);
        in_data = 2'd1;
        repeat (3) @(negedge clk);
        chk("fill_held_count", 32'(count), 32'd4);
        chk("fill_held_ready", 32'(in_ready), 32'd0);

        // Release the downstream loop: the fifth symbol is taken after a pop.
        ack_auto = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 100; i++) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) break;
        end
        in_valid = 1'b0;
        chk("fill_5th_accepted", 32'(acc), 32'd1);
        for (int i = 0; i < 300 && launches.size() < 6; i++) @(negedge clk);
        chk("order_len", 32'(launches.size()), 32'd6);
        for (int i = 0; i < 6 && i < launches.size(); i++)
            chk("order_sym", 32'(launches[i]), 32'(exp_l[i]));
        repeat (12) @(negedge clk);

        // Stale ack held through reset release.
        ack_auto = 1'b0; ack_man = 1'b1; init_n = 1'b0;
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        in_valid = 1'b1; in_data = 2'd3;
        @(negedge clk);
        @(negedge clk); in_data = 2'd1;
        @(negedge clk); in_valid = 1'b0;
        chk("stale_count", 32'(count), 32'd2);
        repeat (8) @(negedge clk);
        chk("stale_hold", 32'(mr_out), 32'd0);
        ack_man = 1'b0;
        @(negedge clk);
        chk("stale_edge1", 32'(mr_out), 32'd0);
        @(negedge clk);
        chk("stale_edge2", 32'(mr_out), 32'd0);
        @(negedge clk);
        chk("stale_launch", 32'(mr_out), 32'b1000);

        // DATA held with no acknowledge: watchdog behaviour.
        repeat (15) @(negedge clk);
        chk("wdog_before", 32'(err), 32'd0);
        @(negedge clk);
`ifdef NCL_MR_TX_WDOG_EN
        chk("wdog_rise", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        chk("wdog_sticky", 32'(err), 32'd1);
`else
        chk("wdog_off", 32'(err), 32'd0);
        repeat (5) @(negedge clk);
`endif
        chk("mid_data", 32'(mr_out), 32'b1000);
        chk("mid_count", 32'(count), 32'd1);

        // Asynchronous reset in the middle of a DATA wavefront.
        @(posedge clk); #2;
        init_n = 1'b0;
        #1;
        chk("async_mr_out", 32'(mr_out), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
